// File: rtl/vcfg_sequencer.sv
// ---------------------------------------------------------------------------
// vcfg_sequencer
//
// Purpose:
//   Steps a vsetvli / vsetivli / vsetvl instruction through the vector config
//   unit. One request is accepted from scalar issue. The sequencer then waits
//   for the vector pipe to drain and pulses the config unit for one cycle with
//   the decoded controls. Finally it returns the new vl to scalar rd over a
//   valid/ready writeback port. Vector issue is stalled for the whole sequence.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  config request handshake (ready only while idle)
//   req_type             00 vsetvli, 01 vsetivli, 10/11 vsetvl
//   req_avl              rs1 value or zero-extended uimm
//   req_rs1_zero         rs1 field is x0 (ignored for vsetivli)
//   req_rd               destination register
//   req_vtype            new vtype
//   vec_idle             vector pipe has no in-flight ops
//   issue_stall          blocks vector issue while a sequence is running
//   cfg_en               one-cycle enable to the config unit
//   cfg_type, cfg_avl_set, cfg_avl_new, cfg_vtype
//                        captured controls, valid while cfg_en is high
//   cfg_avl, cfg_vill    current vl / vill from the config unit
//   wb_valid/wb_ready    scalar writeback handshake
//   wb_rd, wb_data       writeback register and zero-extended vl
//   trap_valid/trap_ready
//                        illegal-vtype trap handshake (VCFG_VILL_TRAP_EN only)
//
// Configuration:
//   VCFG_VILL_TRAP_EN    when defined, a vill result raises trap_valid
//                        instead of writing back; otherwise vill is ignored.
// ---------------------------------------------------------------------------
module vcfg_sequencer #(
    parameter int XLEN        = 32,
    parameter int VLEN        = 16384,
    parameter int VLMAX       = VLEN >> 3,
    parameter int VLEN_B_BITS = $clog2(VLMAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_type,
    input  logic [31:0]            req_avl,
    input  logic                   req_rs1_zero,
    input  logic [4:0]             req_rd,
    input  logic [XLEN-1:0]        req_vtype,
    input  logic                   vec_idle,
    output logic                   issue_stall,
    output logic                   cfg_en,
    output logic [1:0]             cfg_type,
    output logic [1:0]             cfg_avl_set,
    output logic [31:0]            cfg_avl_new,
    output logic [XLEN-1:0]        cfg_vtype,
    input  logic [VLEN_B_BITS:0]   cfg_avl,
    input  logic                   cfg_vill,
`ifdef VCFG_VILL_TRAP_EN
    output logic                   trap_valid,
    input  logic                   trap_ready,
`endif
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2,
        WB    = 2'd3
    } state_e;

    localparam logic [1:0] AVL_REG  = 2'b00;
    localparam logic [1:0] AVL_MAX  = 2'b01;
    localparam logic [1:0] AVL_IMM  = 2'b10;
    localparam logic [1:0] AVL_KEEP = 2'b11;

    localparam int WB_PAD = XLEN - VLEN_B_BITS - 1;

    state_e            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        avl_set_q, avl_set_d;
    logic [31:0]       avl_q, avl_d;
    logic [XLEN-1:0]   vtype_q, vtype_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        avl_set_dec;

    // AVL mode is decoded from the live request so that only the two-bit
    // result has to be stored, not rs1_zero as well. Type 11 falls through
    // to the vsetvl path because only 01 selects the immediate form.
    always_comb begin
        avl_set_dec = AVL_REG;
        if (req_type == 2'b01) begin
            avl_set_dec = AVL_IMM;
        end else if (!req_rs1_zero) begin
            avl_set_dec = AVL_REG;
        end else if (req_rd != 5'd0) begin
            avl_set_dec = AVL_MAX;
        end else begin
            avl_set_dec = AVL_KEEP;
        end
    end

    // Next-state and output logic. The request is captured only in IDLE,
    // so the cfg_* and wb_rd values stay frozen for the rest of the sequence.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        avl_set_d   = avl_set_q;
        avl_d       = avl_q;
        vtype_d     = vtype_q;
        rd_d        = rd_q;
        req_ready   = 1'b0;
        issue_stall = 1'b1;
        cfg_en      = 1'b0;
        wb_valid    = 1'b0;
`ifdef VCFG_VILL_TRAP_EN
        trap_valid  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready   = 1'b1;
                issue_stall = 1'b0;
                if (req_valid) begin
                    type_d    = req_type;
                    avl_set_d = avl_set_dec;
                    avl_d     = req_avl;
                    vtype_d   = req_vtype;
                    rd_d      = req_rd;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (vec_idle) begin
                    state_d = CFG;
                end
            end
            CFG: begin
                cfg_en = 1'b1;
`ifdef VCFG_VILL_TRAP_EN
                // vill is only known after the config unit updates, so an
                // rd==x0 request still has to visit WB to look at it.
                state_d = WB;
`else
                state_d = (rd_q != 5'd0) ? WB : IDLE;
`endif
            end
            WB: begin
`ifdef VCFG_VILL_TRAP_EN
                if (cfg_vill) begin
                    trap_valid = 1'b1;
                    if (trap_ready) begin
                        state_d = IDLE;
                    end
                end else if (rd_q == 5'd0) begin
                    state_d = IDLE;
                end else begin
                    wb_valid = 1'b1;
                    if (wb_ready) begin
                        state_d = IDLE;
                    end
                end
`else
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers. A reset abandons any sequence in
    // progress; the config unit itself is not rolled back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            type_q    <= 2'b00;
            avl_set_q <= 2'b00;
            avl_q     <= 32'd0;
            vtype_q   <= '0;
            rd_q      <= 5'd0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            avl_set_q <= avl_set_d;
            avl_q     <= avl_d;
            vtype_q   <= vtype_d;
            rd_q      <= rd_d;
        end
    end

    assign cfg_type    = type_q;
    assign cfg_avl_set = avl_set_q;
    assign cfg_avl_new = avl_q;
    assign cfg_vtype   = vtype_q;
    assign wb_rd       = rd_q;
    // The config unit updated vl on the CFG edge, so it is settled in WB.
    assign wb_data     = {{WB_PAD{1'b0}}, cfg_avl};

`ifndef VCFG_VILL_TRAP_EN
    logic unused_vill;
    assign unused_vill = cfg_vill;
`endif

endmodule

// File: tb/tb_vcfg_sequencer.sv
module tb_vcfg_sequencer;

    localparam int XLEN  = 32;
    localparam int VLMAX = 2048;
    localparam int AW    = 12;
`ifdef VCFG_VILL_TRAP_EN
    localparam int RD0_LAT = 4;
`else
    localparam int RD0_LAT = 3;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [31:0]       req_avl;
    logic              req_rs1_zero;
    logic [4:0]        req_rd;
    logic [XLEN-1:0]   req_vtype;
    logic              vec_idle;
    logic              issue_stall;
    logic              cfg_en;
    logic [1:0]        cfg_type;
    logic [1:0]        cfg_avl_set;
    logic [31:0]       cfg_avl_new;
    logic [XLEN-1:0]   cfg_vtype;
    logic [AW-1:0]     cfg_avl;
    logic              cfg_vill;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
`ifdef VCFG_VILL_TRAP_EN
    logic              trap_valid;
    logic              trap_ready;
    assign trap_ready = wb_ready;
`endif

    vcfg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_avl      (req_avl),
        .req_rs1_zero (req_rs1_zero),
        .req_rd       (req_rd),
        .req_vtype    (req_vtype),
        .vec_idle     (vec_idle),
        .issue_stall  (issue_stall),
        .cfg_en       (cfg_en),
        .cfg_type     (cfg_type),
        .cfg_avl_set  (cfg_avl_set),
        .cfg_avl_new  (cfg_avl_new),
        .cfg_vtype    (cfg_vtype),
        .cfg_avl      (cfg_avl),
        .cfg_vill     (cfg_vill),
`ifdef VCFG_VILL_TRAP_EN
        .trap_valid   (trap_valid),
        .trap_ready   (trap_ready),
`endif
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in config unit: updates vl/vill on the cfg_en edge and is never
    // reset, like the real unit.
    logic [AW-1:0] stubAvl  = '0;
    logic          stubVill = 1'b0;
    always @(posedge clk) begin
        if (cfg_en) begin
            case (cfg_avl_set)
                2'b00, 2'b10: stubAvl <= (cfg_avl_new >= 32'(VLMAX)) ? AW'(VLMAX) : cfg_avl_new[AW-1:0];
                2'b01:        stubAvl <= AW'(VLMAX);
                default:      stubAvl <= stubAvl;
            endcase
            stubVill <= cfg_vtype[XLEN-1];
        end
    end
    assign cfg_avl  = stubAvl;
    assign cfg_vill = stubVill;

    typedef struct {
        logic [1:0]  typ;
        logic [1:0]  set;
        logic [31:0] avl;
        logic [31:0] vtype;
    } cfgExp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] avl;
        logic        rs1Zero;
        logic [4:0]  rd;
        logic [31:0] vtype;
        logic [1:0]  expSet;
        logic        expWb;
        logic [31:0] expData;
    } vec_t;

    cfgExp_t cfgQ[$];
    wbExp_t  wbQ[$];
    cfgExp_t mCfg;
    wbExp_t  mWb;
    vec_t    vecs[12];
    int      checks   = 0;
    int      failures = 0;
    int      trapSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectCfg(input logic [1:0] t, input logic [1:0] s, input logic [31:0] a, input logic [31:0] vt);
        cfgExp_t e;
        e.typ = t; e.set = s; e.avl = a; e.vtype = vt;
        cfgQ.push_back(e);
    endtask

    task automatic expectWb(input logic [4:0] r, input logic [31:0] d);
        wbExp_t e;
        e.rd = r; e.data = d;
        wbQ.push_back(e);
    endtask

    task automatic driveReq(input logic [1:0] t, input logic [31:0] a, input logic z, input logic [4:0] r, input logic [31:0] vt);
        req_type = t; req_avl = a; req_rs1_zero = z; req_rd = r; req_vtype = vt;
        req_valid = 1'b1;
    endtask

    task automatic waitIdle(output int n);
        n = 1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    // Scoreboard side: compare config pulses and writeback handshakes with
    // the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_en) begin
                if (cfgQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL cfg_unexpected: got cfg_en=1 expected no pulse");
                end else begin
                    mCfg = cfgQ.pop_front();
                    checkOutput("cfg_type", 32'(cfg_type), 32'(mCfg.typ));
                    checkOutput("cfg_avl_set", 32'(cfg_avl_set), 32'(mCfg.set));
                    checkOutput("cfg_avl_new", cfg_avl_new, mCfg.avl);
                    checkOutput("cfg_vtype", cfg_vtype, mCfg.vtype);
                end
            end
            if (wb_valid && wb_ready) begin
                if (wbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no writeback", wb_rd);
                end else begin
                    mWb = wbQ.pop_front();
                    checkOutput("wb_rd", 32'(wb_rd), 32'(mWb.rd));
                    checkOutput("wb_data", wb_data, mWb.data);
                end
            end
`ifdef VCFG_VILL_TRAP_EN
            if (trap_valid && trap_ready) trapSeen++;
`endif
        end
    end

    task automatic applyStimulus(input vec_t v);
        int lat;
        int expLat;
        int trapBefore;
        logic wbExp;
        int trapExp;
        wbExp   = v.expWb;
        trapExp = 0;
`ifdef VCFG_VILL_TRAP_EN
        if (v.vtype[XLEN-1]) begin
            wbExp   = 1'b0;
            trapExp = 1;
        end
`endif
        expLat = (v.rd != 5'd0) ? 4 : RD0_LAT;
        expectCfg(v.typ, v.expSet, v.avl, v.vtype);
        if (wbExp) expectWb(v.rd, v.expData);
        trapBefore = trapSeen;
        driveReq(v.typ, v.avl, v.rs1Zero, v.rd, v.vtype);
        tick();
        req_valid = 1'b0;
        waitIdle(lat);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("cfg_pending", 32'(cfgQ.size()), 32'd0);
        checkOutput("wb_pending", 32'(wbQ.size()), 32'd0);
        checkOutput("trap_count", 32'(trapSeen - trapBefore), 32'(trapExp));
    endtask

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100us");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat;
        //            typ    avl      z     rd     vtype          set    wb    data
        vecs[0]  = '{2'b00, 32'd17,   1'b0, 5'd5,  32'h0,        2'b00, 1'b1, 32'd17};
        vecs[1]  = '{2'b00, 32'd999,  1'b1, 5'd3,  32'h0,        2'b01, 1'b1, 32'd2048};
        vecs[2]  = '{2'b00, 32'd55,   1'b1, 5'd0,  32'h0,        2'b11, 1'b0, 32'd0};
        vecs[3]  = '{2'b01, 32'd9,    1'b1, 5'd7,  32'h0,        2'b10, 1'b1, 32'd9};
        vecs[4]  = '{2'b10, 32'd2049, 1'b0, 5'd31, 32'h0,        2'b00, 1'b1, 32'd2048};
        vecs[5]  = '{2'b11, 32'd100,  1'b1, 5'd1,  32'h0,        2'b01, 1'b1, 32'd2048};
        vecs[6]  = '{2'b10, 32'd77,   1'b1, 5'd0,  32'h0,        2'b11, 1'b0, 32'd0};
        vecs[7]  = '{2'b01, 32'd31,   1'b0, 5'd0,  32'h0,        2'b10, 1'b0, 32'd0};
        vecs[8]  = '{2'b00, 32'd2048, 1'b0, 5'd2,  32'h000000d3, 2'b00, 1'b1, 32'd2048};
        vecs[9]  = '{2'b00, 32'd0,    1'b0, 5'd4,  32'h0,        2'b00, 1'b1, 32'd0};
        vecs[10] = '{2'b00, 32'd3,    1'b0, 5'd10, 32'h80000000, 2'b00, 1'b1, 32'd3};
        vecs[11] = '{2'b01, 32'd12,   1'b0, 5'd6,  32'h0,        2'b10, 1'b1, 32'd12};

        rst = 1'b1; req_valid = 1'b0; req_type = 2'b00; req_avl = 32'd0;
        req_rs1_zero = 1'b0; req_rd = 5'd0; req_vtype = '0;
        vec_idle = 1'b1; wb_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_issue_stall", 32'(issue_stall), 32'd0);
        checkOutput("rst_cfg_en", 32'(cfg_en), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_cfg_avl_new", cfg_avl_new, 32'd0);
        checkOutput("rst_cfg_vtype", cfg_vtype, 32'd0);
        checkOutput("rst_cfg_avl_set", 32'(cfg_avl_set), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        rst = 1'b0;

        // Cycle-exact minimum latency
        expectCfg(2'b00, 2'b00, 32'd200, 32'h0);
        expectWb(5'd13, 32'd200);
        driveReq(2'b00, 32'd200, 1'b0, 5'd13, 32'h0);
        tick();
        req_valid = 1'b0;
        checkOutput("c1_cfg_en", 32'(cfg_en), 32'd0);
        checkOutput("c1_issue_stall", 32'(issue_stall), 32'd1);
        checkOutput("c1_req_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("c2_cfg_en", 32'(cfg_en), 32'd1);
        checkOutput("c2_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        checkOutput("c3_cfg_en", 32'(cfg_en), 32'd0);
        checkOutput("c3_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("c3_wb_rd", 32'(wb_rd), 32'd13);
        checkOutput("c3_wb_data", wb_data, 32'd200);
        tick();
        checkOutput("c4_req_ready", 32'(req_ready), 32'd1);
        checkOutput("c4_issue_stall", 32'(issue_stall), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
        end

        // Drain wait: vec_idle low for 6 cycles after accept
        vec_idle = 1'b0;
        expectCfg(2'b00, 2'b00, 32'd64, 32'h0);
        expectWb(5'd14, 32'd64);
        driveReq(2'b00, 32'd64, 1'b0, 5'd14, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("drain_cfg_en", 32'(cfg_en), 32'd0);
            checkOutput("drain_stall", 32'(issue_stall), 32'd1);
            tick();
        end
        vec_idle = 1'b1;
        checkOutput("drain_cfg_en_last", 32'(cfg_en), 32'd0);
        tick();
        checkOutput("drain_cfg_en_rise", 32'(cfg_en), 32'd1);
        vec_idle = 1'b0;
        waitIdle(lat);
        vec_idle = 1'b1;
        checkOutput("drain_wb_pending", 32'(wbQ.size()), 32'd0);

        // Writeback stall with a second request waiting
        wb_ready = 1'b0;
        expectCfg(2'b00, 2'b00, 32'd33, 32'h0);
        expectWb(5'd9, 32'd33);
        driveReq(2'b00, 32'd33, 1'b0, 5'd9, 32'h0);
        tick();
        expectCfg(2'b01, 2'b10, 32'd40, 32'h0);
        expectWb(5'd12, 32'd40);
        driveReq(2'b01, 32'd40, 1'b0, 5'd12, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("stall_wb_rd", 32'(wb_rd), 32'd9);
            checkOutput("stall_wb_data", wb_data, 32'd33);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        checkOutput("post_hs_req_ready", 32'(req_ready), 32'd1);
        checkOutput("post_hs_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        checkOutput("second_accepted", 32'(req_ready), 32'd0);
        waitIdle(lat);
        checkOutput("stall_wb_pending", 32'(wbQ.size()), 32'd0);

        // Reset while in DRAIN
        vec_idle = 1'b0;
        driveReq(2'b00, 32'd10, 1'b0, 5'd6, 32'h0);
        tick();
        req_valid = 1'b0;
        checkOutput("rdrain_busy", 32'(issue_stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rdrain_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rdrain_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rdrain_cfg_en", 32'(cfg_en), 32'd0);
        checkOutput("rdrain_avl_new", cfg_avl_new, 32'd0);
        vec_idle = 1'b1;
        tick();
        checkOutput("rdrain_no_cfg", 32'(cfg_en), 32'd0);
        checkOutput("rdrain_still_idle", 32'(req_ready), 32'd1);
        applyStimulus(vecs[0]);

        // Reset while in WB
        wb_ready = 1'b0;
        expectCfg(2'b00, 2'b00, 32'd20, 32'h0);
        driveReq(2'b00, 32'd20, 1'b0, 5'd8, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("rwb_wb_valid", 32'(wb_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rwb_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rwb_wb_valid_drop", 32'(wb_valid), 32'd0);
        checkOutput("rwb_cfg_en", 32'(cfg_en), 32'd0);
        checkOutput("rwb_wb_rd", 32'(wb_rd), 32'd0);
        wb_ready = 1'b1;
        applyStimulus(vecs[3]);

        checkOutput("final_cfg_pending", 32'(cfgQ.size()), 32'd0);
        checkOutput("final_wb_pending", 32'(wbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
